ram_access_ctrl: RTL and testbench

- Sits directly upstream of the 16x4 synchronous RAM and drives its cs, we, address and data_in.
- Turns raw active-low push-buttons and switches into clean, single-cycle RAM write and read transactions.
- Captures read data into a held display register.
- Replaces the current direct pin-to-RAM wiring, in which a bouncing button acts as the RAM clock.

---
 rtl/ram_pkg.sv | 16 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/ram_access_ctrl.sv | 103 ++++++++++
 tb/tb_ram_access_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared RAM geometry defaults and FSM state encoding for the RAM access controller.
package ram_pkg;

   localparam int AW_DEF    = 4;
   localparam int DW_DEF    = 4;
   localparam int RAM_DEPTH = 2 ** AW_DEF;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WRITE    = 3'd1,
      READ     = 3'd2,
      CAPTURE  = 3'd3,
      WAIT_REL = 3'd4
   } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Active-low button conditioner: 2-flop synchronizer, stable-count debouncer and a
// one-cycle press pulse that is asserted together with the debounced level rising.
module btn_debounce #(
   parameter int DB_COUNT = 50000,
   parameter int DB_W     = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic level,
   output logic press
);

   logic [1:0]      sync_q;
   logic [DB_W-1:0] cnt;
   logic            sync_lvl;

   assign sync_lvl = ~sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         cnt    <= '0;
         level  <= 1'b0;
         press  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_n};
         press  <= 1'b0;
         if (sync_lvl == level) begin
            cnt <= '0;
         end else if (cnt == DB_W'(DB_COUNT - 1)) begin
            // DB_COUNT consecutive disagreeing cycles: accept the new level
            cnt   <= '0;
            level <= sync_lvl;
            press <= sync_lvl;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_access_ctrl.sv
// Push-button front end for the 16x4 synchronous RAM: one clean strobe per press.
// Build option RAM_AUTO_INC_EN: internal auto-incrementing address pointer.
module ram_access_ctrl
   import ram_pkg::*;
#(
   parameter int DB_COUNT = 50000,
   parameter int DB_W     = 16,
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          btn_wr_n,
   input  logic          btn_rd_n,
   input  logic [AW-1:0] sw_addr_n,
   input  logic [DW-1:0] sw_data_n,
   input  logic [DW-1:0] ram_dout,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic [DW-1:0] disp_data,
   output logic          busy
);

   logic    wr_lvl, wr_press, rd_lvl, rd_press;
   state_t  state, state_nx;
   logic    leave_idle;
   logic [AW-1:0] addr_src;

   btn_debounce #(.DB_COUNT(DB_COUNT), .DB_W(DB_W)) u_db_wr (
      .clk(clk), .rst_n(rst_n), .btn_n(btn_wr_n), .level(wr_lvl), .press(wr_press)
   );

   btn_debounce #(.DB_COUNT(DB_COUNT), .DB_W(DB_W)) u_db_rd (
      .clk(clk), .rst_n(rst_n), .btn_n(btn_rd_n), .level(rd_lvl), .press(rd_press)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (wr_press)      state_nx = WRITE;
            else if (rd_press) state_nx = READ;
         end
         WRITE:    state_nx = WAIT_REL;
         READ:     state_nx = CAPTURE;
         CAPTURE:  state_nx = WAIT_REL;
         WAIT_REL: if (!wr_lvl && !rd_lvl) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   assign leave_idle = (state == IDLE) && (state_nx != IDLE);
   assign busy       = (state != IDLE);

   // Strobes are decoded from the next state so they are flop outputs aligned with the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ram_cs    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         disp_data <= '0;
      end else begin
         state  <= state_nx;
         ram_cs <= (state_nx == WRITE) || (state_nx == READ);
         ram_we <= (state_nx == WRITE);
         if (leave_idle) begin
            ram_addr <= addr_src;
            ram_din  <= ~sw_data_n;
         end
         if (state == CAPTURE) disp_data <= ram_dout;
      end
   end

`ifdef RAM_AUTO_INC_EN
   logic [AW-1:0]   ptr;
   logic [DB_W-1:0] clr_cnt;
   logic            hold_both;

   assign hold_both = wr_lvl && rd_lvl && ((state == IDLE) || (state == WAIT_REL));
   assign addr_src  = ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= '0;
         clr_cnt <= '0;
      end else begin
         if (!hold_both)                         clr_cnt <= '0;
         else if (clr_cnt != DB_W'(DB_COUNT))    clr_cnt <= clr_cnt + 1'b1;
         if ((state == WRITE) || (state == CAPTURE))
            ptr <= ptr + 1'b1;
         else if (hold_both && (clr_cnt == DB_W'(DB_COUNT - 1)))
            ptr <= '0;
      end
   end
`else
   assign addr_src = ~sw_addr_n;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a behavioural 16x4 synchronous RAM (DB_COUNT=4).
module tb_ram_access_ctrl;

   localparam int AW = 4;
   localparam int DW = 4;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic [DW-1:0] rd;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          btn_wr_n, btn_rd_n;
   logic [AW-1:0] sw_addr_n;
   logic [DW-1:0] sw_data_n;
   logic [DW-1:0] ram_dout;
   logic          ram_cs, ram_we, busy;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, disp_data;

   logic [DW-1:0] mem [16];
   exp_t          exp_q[$];
   int            vectors = 0, miscompares = 0;
   int            cyc = 0, n_strobe = 0, last_cyc = 0, rd_cnt = 0;
   logic [DW-1:0] disp_exp;

   ram_access_ctrl #(.DB_COUNT(4), .DB_W(16), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .btn_wr_n(btn_wr_n), .btn_rd_n(btn_rd_n),
      .sw_addr_n(sw_addr_n), .sw_data_n(sw_data_n), .ram_dout(ram_dout),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .disp_data(disp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_cs && ram_we)  mem[ram_addr] <= ram_din;
      if (ram_cs && !ram_we) ram_dout <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the head of the scoreboard; reads schedule a disp check
   always @(negedge clk) begin
      if (!rst_n) begin
         rd_cnt = 0;
      end else begin
         if (rd_cnt != 0) begin
            rd_cnt--;
            if (rd_cnt == 0) chk("disp_data", disp_data, disp_exp);
         end
         if (ram_cs) begin
            n_strobe++;
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", {ram_we, ram_addr, ram_din}, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("we", ram_we, e.we);
               chk("addr", ram_addr, e.addr);
               if (e.we) chk("din", ram_din, e.din);
               else begin
                  rd_cnt   = 2;
                  disp_exp = e.rd;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic exp_t mk(input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] r);
      exp_t e;
      e.we = we; e.addr = a; e.din = d; e.rd = r;
      return e;
   endfunction

   // Press one or both buttons, hold, release and let the FSM return to IDLE
   task automatic press(input logic wr, input logic rd, input int hold, output int t0);
      if (wr) btn_wr_n = 1'b0;
      if (rd) btn_rd_n = 1'b0;
      t0 = cyc;
      tick(hold);
      btn_wr_n = 1'b1;
      btn_rd_n = 1'b1;
      tick(20);
   endtask

   initial begin
      int t0, n0, guard;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      ram_dout  = '0;
      rst_n     = 1'b0;
      btn_wr_n  = 1'b1;
      btn_rd_n  = 1'b1;
      sw_addr_n = '1;
      sw_data_n = '1;
      #2;
      chk("rst_outs", {ram_cs, ram_we, busy, ram_addr, ram_din, disp_data}, 0);
      tick(2);
      rst_n = 1'b1;
      tick(5);

`ifdef RAM_AUTO_INC_EN
      for (int i = 0; i < 17; i++) begin
         sw_data_n = ~4'(i);
         exp_q.push_back(mk(1'b1, 4'(i % 16), 4'(i), 4'h0));
         press(1'b1, 1'b0, 20, t0);
      end
      chk("ai_q_empty", exp_q.size(), 0);
      // both together: write wins at pointer 1, then the WAIT_REL hold clears it
      sw_data_n = ~4'hE;
      exp_q.push_back(mk(1'b1, 4'h1, 4'hE, 4'h0));
      press(1'b1, 1'b1, 30, t0);
      sw_data_n = ~4'h7;
      exp_q.push_back(mk(1'b1, 4'h0, 4'h7, 4'h0));
      press(1'b1, 1'b0, 20, t0);
      chk("ai_clear_q_empty", exp_q.size(), 0);
`else
      // write 5 <- A
      sw_addr_n = ~4'h5;
      sw_data_n = ~4'hA;
      exp_q.push_back(mk(1'b1, 4'h5, 4'hA, 4'h0));
      btn_wr_n = 1'b0;
      t0 = cyc;
      tick(12);
      chk("busy_wait_rel", busy, 1'b1);
      tick(8);
      btn_wr_n = 1'b1;
      tick(20);
      chk("wr_latency", last_cyc - t0, 7);
      chk("busy_idle", busy, 1'b0);

      // read 5 -> A
      exp_q.push_back(mk(1'b0, 4'h5, 4'h0, 4'hA));
      press(1'b0, 1'b1, 20, t0);
      chk("rd_latency", last_cyc - t0, 7);
      chk("disp_held", disp_data, 4'hA);

      // bounce then stable low: write 2 <- 3
      sw_addr_n = ~4'h2;
      sw_data_n = ~4'h3;
      exp_q.push_back(mk(1'b1, 4'h2, 4'h3, 4'h0));
      n0 = n_strobe;
      for (int i = 0; i < 10; i++) begin
         btn_wr_n = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(2);
      end
      chk("bounce_no_strobe", n_strobe - n0, 0);
      press(1'b1, 1'b0, 20, t0);
      chk("bounce_latency", last_cyc - t0, 7);
      chk("bounce_one_strobe", n_strobe - n0, 1);

      // simultaneous: write 6 <- 9 only
      sw_addr_n = ~4'h6;
      sw_data_n = ~4'h9;
      exp_q.push_back(mk(1'b1, 4'h6, 4'h9, 4'h0));
      n0 = n_strobe;
      press(1'b1, 1'b1, 20, t0);
      chk("simul_one_strobe", n_strobe - n0, 1);
      chk("simul_disp_kept", disp_data, 4'hA);

      // long write hold with a read press in the middle: write 7 <- C only
      sw_addr_n = ~4'h7;
      sw_data_n = ~4'hC;
      exp_q.push_back(mk(1'b1, 4'h7, 4'hC, 4'h0));
      n0 = n_strobe;
      btn_wr_n = 1'b0;
      tick(50);
      btn_rd_n = 1'b0;
      tick(20);
      btn_rd_n = 1'b1;
      tick(130);
      btn_wr_n = 1'b1;
      tick(20);
      chk("hold_one_strobe", n_strobe - n0, 1);

      // fresh read presses now take effect
      exp_q.push_back(mk(1'b0, 4'h7, 4'h0, 4'hC));
      press(1'b0, 1'b1, 20, t0);
      sw_addr_n = ~4'h6;
      exp_q.push_back(mk(1'b0, 4'h6, 4'h0, 4'h9));
      press(1'b0, 1'b1, 20, t0);
      chk("q_empty", exp_q.size(), 0);

      // reset during CAPTURE
      sw_addr_n = ~4'h5;
      exp_q.push_back(mk(1'b0, 4'h5, 4'h0, 4'hA));
      n0 = n_strobe;
      btn_rd_n = 1'b0;
      guard = 0;
      while (n_strobe == n0 && guard < 50) begin
         tick(1);
         guard++;
      end
      chk("rst_read_seen", n_strobe - n0, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("rst_async_outs", {ram_cs, ram_we, busy, ram_addr, ram_din, disp_data}, 0);
      btn_rd_n = 1'b1;
      tick(3);
      rst_n = 1'b1;
      n0 = n_strobe;
      tick(30);
      chk("rst_no_stale", n_strobe - n0, 0);
      chk("rst_disp_zero", disp_data, 0);
      chk("rst_busy", busy, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
